fsqrt_iter: RTL and testbench

FSQRT_ITER -- requirements
Module: fsqrt_iter

---
 rtl/fpu_pkg.sv | 18 +
 rtl/fsqrt_step.sv | 29 ++
 rtl/fsqrt_iter.sv | 164 ++++++++++++++++
 tb/tb_fsqrt_iter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared constants and FSM encoding for the iterative floating-point square root.
package fpu_pkg;

    localparam int FLOAT_W   = 32;
    localparam int EXP_BIAS  = 127;
    localparam int ROOT_BITS = 25;
    localparam int REM_W     = 28;

    localparam logic [FLOAT_W-1:0] QNAN = 32'h7FC0_0000;
    localparam logic [FLOAT_W-1:0] PINF = 32'h7F80_0000;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_CALC  = 2'd1;
    localparam state_t S_ROUND = 2'd2;
    localparam state_t S_DONE  = 2'd3;

endpackage

// File: rtl/fsqrt_step.sv
// One non-restoring square-root digit: consumes a radicand bit pair, retires one root bit.
module fsqrt_step
    import fpu_pkg::*;
(
    input  logic [REM_W-1:0]     rem_in,
    input  logic [ROOT_BITS-1:0] root_in,
    input  logic [1:0]           pair,
    output logic [REM_W-1:0]     rem_out,
    output logic [ROOT_BITS-1:0] root_out
);

    logic [REM_W+1:0] shifted;
    logic [REM_W+1:0] sub_term;
    logic [REM_W+1:0] add_term;
    logic [REM_W+1:0] sum;
    logic             unused_bits;

    // Remainder stays within +/-(2*root+1), so 4*rem fits the widened sum.
    assign shifted  = {rem_in, pair};
    assign sub_term = {{(REM_W-ROOT_BITS){1'b0}}, root_in, 2'b01};
    assign add_term = {{(REM_W-ROOT_BITS){1'b0}}, root_in, 2'b11};
    assign sum      = rem_in[REM_W-1] ? (shifted + add_term) : (shifted - sub_term);

    assign rem_out  = sum[REM_W-1:0];
    assign root_out = {root_in[ROOT_BITS-2:0], ~sum[REM_W+1]};

    assign unused_bits = ^{sum[REM_W], root_in[ROOT_BITS-1]};

endmodule

// File: rtl/fsqrt_iter.sv
// Iterative IEEE-754 single-precision square root, round-to-nearest, valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for an operand (in_ready high)
// CALC  | retiring DIGITS_PER_CYCLE root bits per cycle, ITER cycles
// ROUND | round-to-nearest and pack the result into y
// DONE  | result presented until out_ready
module fsqrt_iter
    import fpu_pkg::*;
#(
    parameter int DIGITS_PER_CYCLE = 1,
    parameter int FLUSH_DENORM     = 1
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOAT_W-1:0] x,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [FLOAT_W-1:0] y,
    output logic               invalid,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int ITER  = ROOT_BITS / DIGITS_PER_CYCLE;
    localparam int RAD_W = 2 * ROOT_BITS;

    if (!(DIGITS_PER_CYCLE == 1 || DIGITS_PER_CYCLE == 5 || DIGITS_PER_CYCLE == 25)) begin : g_bad_dpc
        $error("fsqrt_iter: DIGITS_PER_CYCLE must be 1, 5 or 25");
    end
    if (FLUSH_DENORM != 1) begin : g_bad_flush
        $error("fsqrt_iter: only FLUSH_DENORM=1 is supported");
    end

    state_t               state;
    logic [4:0]           cnt;
    logic [RAD_W-1:0]     rad;
    logic [REM_W-1:0]     rem;
    logic [ROOT_BITS-1:0] root;
    logic [7:0]           res_exp;

    logic                 sgn;
    logic [7:0]           e;
    logic [22:0]          m;
    logic                 special;
    logic                 spec_inv;
    logic [FLOAT_W-1:0]   spec_y;
    logic [RAD_W-1:0]     rad_init;
    logic [7:0]           exp_init;

    assign sgn = x[31];
    assign e   = x[30:23];
    assign m   = x[22:0];

    always_comb begin
        special  = 1'b1;
        spec_inv = 1'b0;
        spec_y   = {sgn, 31'b0};
        if (e == 8'h00) begin
            spec_y = {sgn, 31'b0};
        end else if (e == 8'hFF && m != 23'b0) begin
            spec_y   = QNAN;
            spec_inv = 1'b1;
        end else if (sgn) begin
            spec_y   = QNAN;
            spec_inv = 1'b1;
        end else if (e == 8'hFF) begin
            spec_y = PINF;
        end else begin
            special = 1'b0;
        end
    end

    // Even biased exponent means odd unbiased exponent: radicand 1.m is doubled.
    assign rad_init = e[0] ? {1'b0, 1'b1, m, 1'b0, {(ROOT_BITS-1){1'b0}}}
                           : {1'b1, m, 2'b00, {(ROOT_BITS-1){1'b0}}};
    assign exp_init = {1'b0, e[7:1]} + 8'(EXP_BIAS / 2) + {7'b0, e[0]};

    logic [REM_W-1:0]     rem_c  [DIGITS_PER_CYCLE+1];
    logic [ROOT_BITS-1:0] root_c [DIGITS_PER_CYCLE+1];

    assign rem_c[0]  = rem;
    assign root_c[0] = root;

    for (genvar i = 0; i < DIGITS_PER_CYCLE; i++) begin : g_step
        fsqrt_step u_step (
            .rem_in   (rem_c[i]),
            .root_in  (root_c[i]),
            .pair     (rad[RAD_W-1-2*i -: 2]),
            .rem_out  (rem_c[i+1]),
            .root_out (root_c[i+1])
        );
    end

    logic [REM_W-1:0]     rem_fix;
    logic                 round_up;
    logic [ROOT_BITS-1:0] mant;
    logic [22:0]          frac;
    logic [7:0]           exp_out;

    // A negative non-restoring remainder is one (2*root+1) short of the true one.
    assign rem_fix  = rem[REM_W-1] ? (rem + {{(REM_W-ROOT_BITS-1){1'b0}}, root, 1'b1}) : rem;
    assign round_up = root[0] & ((|rem_fix) | root[1]);
    assign mant     = {1'b0, root[ROOT_BITS-1:1]} + {{(ROOT_BITS-1){1'b0}}, round_up};
    assign frac     = mant[ROOT_BITS-1] ? mant[23:1] : mant[22:0];
    assign exp_out  = res_exp + {7'b0, mant[ROOT_BITS-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 5'd0;
            rad     <= '0;
            rem     <= '0;
            root    <= '0;
            res_exp <= 8'd0;
            y       <= '0;
            invalid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (special) begin
                            y       <= spec_y;
                            invalid <= spec_inv;
                            state   <= S_DONE;
                        end else begin
                            rad     <= rad_init;
                            rem     <= '0;
                            root    <= '0;
                            res_exp <= exp_init;
                            invalid <= 1'b0;
                            cnt     <= 5'(ITER - 1);
                            state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rad  <= rad << (2 * DIGITS_PER_CYCLE);
                    rem  <= rem_c[DIGITS_PER_CYCLE];
                    root <= root_c[DIGITS_PER_CYCLE];
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    y     <= {1'b0, exp_out, frac};
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_fsqrt_iter.sv
// Directed and swept checks of fsqrt_iter at 1, 5 and 25 digits per cycle.
module tb_fsqrt_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x_a         [3];
    logic [31:0] y_a         [3];
    logic        in_valid_a  [3];
    logic        in_ready_a  [3];
    logic        invalid_a   [3];
    logic        out_valid_a [3];
    logic        out_ready_a [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fsqrt_iter #(.DIGITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .x(x_a[0]), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .y(y_a[0]), .invalid(invalid_a[0]), .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]));
    fsqrt_iter #(.DIGITS_PER_CYCLE(5)) dut5 (
        .clk(clk), .rst(rst), .x(x_a[1]), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .y(y_a[1]), .invalid(invalid_a[1]), .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]));
    fsqrt_iter #(.DIGITS_PER_CYCLE(25)) dut25 (
        .clk(clk), .rst(rst), .x(x_a[2]), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
        .y(y_a[2]), .invalid(invalid_a[2]), .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]));

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        inv;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: exact double sqrt, then round-to-nearest-even to single.
    function automatic logic [31:0] ref_sqrt(input logic [31:0] xb);
        logic [63:0] db;
        logic [63:0] rb;
        real         r;
        logic [22:0] sm;
        logic        g;
        logic        st;
        logic [23:0] sum;
        logic [7:0]  se;
        db  = {1'b0, 11'(int'(xb[30:23]) - 127 + 1023), xb[22:0], 29'b0};
        r   = $sqrt($bitstoreal(db));
        rb  = $realtobits(r);
        sm  = rb[51:29];
        g   = rb[28];
        st  = |rb[27:0];
        sum = {1'b0, sm} + 24'(g & (st | sm[0]));
        se  = 8'(int'(rb[62:52]) - 1023 + 127 + int'(sum[23]));
        return {1'b0, se, sum[22:0]};
    endfunction

    task automatic run_op(input int k, input logic [31:0] xin,
                          output logic [31:0] yo, output logic invo, output int lat);
        int w;
        @(negedge clk);
        x_a[k]        = xin;
        in_valid_a[k] = 1'b1;
        w = 0;
        while (!in_ready_a[k] && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        in_valid_a[k] = 1'b0;
        lat = 1;
        while (!out_valid_a[k] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid_a[k]) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d timeout x=%h: out_valid=0 after %0d cycles, required 1", k, xin, lat);
        end
        yo   = y_a[k];
        invo = invalid_a[k];
        if (out_ready_a[k]) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_sweep(input int k, input int exp_lat);
        logic [31:0] xin;
        logic [31:0] yo;
        logic        invo;
        int          lat;
        logic [22:0] mnt;
        logic [7:0]  ev;
        for (int e = 1; e <= 254; e++) begin
            for (int j = 0; j < 5; j++) begin
                case (j)
                    0:       mnt = 23'h000000;
                    1:       mnt = 23'h000001;
                    2:       mnt = 23'h7FFFFF;
                    3:       mnt = 23'h400000;
                    default: mnt = 23'($urandom);
                endcase
                ev  = 8'(e);
                xin = {1'b0, ev, mnt};
                run_op(k, xin, yo, invo, lat);
                check($sformatf("sweep dut%0d x=%h {inv,y}", k, xin), {31'b0, invo, yo}, {32'b0, ref_sqrt(xin)});
                check($sformatf("sweep dut%0d x=%h latency", k, xin), 64'(lat), 64'(exp_lat));
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] yo;
        logic        invo;
        int          lat;
        logic        saw;

        vecs[0]  = '{32'h4080_0000, 32'h4000_0000, 1'b0, 27};
        vecs[1]  = '{32'h4000_0000, 32'h3FB5_04F3, 1'b0, 27};
        vecs[2]  = '{32'h4110_0000, 32'h4040_0000, 1'b0, 27};
        vecs[3]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b0, 27};
        vecs[4]  = '{32'h3E80_0000, 32'h3F00_0000, 1'b0, 27};
        vecs[5]  = '{32'hBF80_0000, 32'h7FC0_0000, 1'b1, 1};
        vecs[6]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1};
        vecs[7]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1};
        vecs[8]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b0, 1};
        vecs[9]  = '{32'hFF80_0000, 32'h7FC0_0000, 1'b1, 1};
        vecs[10] = '{32'h7FC0_0001, 32'h7FC0_0000, 1'b1, 1};
        vecs[11] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1};
        vecs[12] = '{32'h8000_0001, 32'h8000_0000, 1'b0, 1};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            x_a[k]         = 32'h0;
            in_valid_a[k]  = 1'b0;
            out_ready_a[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset y", 64'(y_a[0]), 64'h0);
        check("reset invalid", 64'(invalid_a[0]), 64'h0);
        check("reset out_valid", 64'(out_valid_a[0]), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready after reset", 64'(in_ready_a[0]), 64'h1);

        for (int i = 0; i < 13; i++) begin
            run_op(0, vecs[i].x, yo, invo, lat);
            check($sformatf("vec%0d x=%h y", i, vecs[i].x), 64'(yo), 64'(vecs[i].y));
            check($sformatf("vec%0d x=%h invalid", i, vecs[i].x), 64'(invo), 64'(vecs[i].inv));
            check($sformatf("vec%0d x=%h latency", i, vecs[i].x), 64'(lat), 64'(vecs[i].lat));
        end

        run_op(1, 32'h4000_0000, yo, invo, lat);
        check("dpc5 sqrt2 y", 64'(yo), 64'h3FB504F3);
        check("dpc5 sqrt2 latency", 64'(lat), 64'd7);
        run_op(2, 32'h4080_0000, yo, invo, lat);
        check("dpc25 sqrt4 y", 64'(yo), 64'h40000000);
        check("dpc25 sqrt4 latency", 64'(lat), 64'd3);

        // Back-pressure: result held for 5 cycles, then next operand offered in the transfer cycle.
        out_ready_a[0] = 1'b0;
        run_op(0, 32'h4000_0000, yo, invo, lat);
        check("stall first y", 64'(yo), 64'h3FB504F3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall%0d y", i), 64'(y_a[0]), 64'h3FB504F3);
            check($sformatf("stall%0d out_valid", i), 64'(out_valid_a[0]), 64'h1);
            check($sformatf("stall%0d in_ready", i), 64'(in_ready_a[0]), 64'h0);
        end
        @(negedge clk);
        out_ready_a[0] = 1'b1;
        x_a[0]         = 32'h4080_0000;
        in_valid_a[0]  = 1'b1;
        @(posedge clk);
        #1;
        check("transfer edge out_valid", 64'(out_valid_a[0]), 64'h0);
        check("transfer edge in_ready", 64'(in_ready_a[0]), 64'h1);
        @(posedge clk);
        #1;
        check("accept after transfer in_ready", 64'(in_ready_a[0]), 64'h0);
        in_valid_a[0] = 1'b0;
        lat = 1;
        while (!out_valid_a[0] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("post-stall op y", 64'(y_a[0]), 64'h40000000);
        check("post-stall op latency", 64'(lat), 64'd27);
        @(posedge clk);
        #1;

        // Reset pulse in the middle of CALC discards the operation.
        @(negedge clk);
        x_a[0]        = 32'h4080_0000;
        in_valid_a[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_a[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst           = 1'b1;
        x_a[0]        = 32'h4110_0000;
        in_valid_a[0] = 1'b1;
        @(posedge clk);
        #1;
        check("mid-calc reset y cleared", 64'(y_a[0]), 64'h0);
        check("mid-calc reset out_valid", 64'(out_valid_a[0]), 64'h0);
        @(negedge clk);
        rst           = 1'b0;
        in_valid_a[0] = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready after mid-calc reset", 64'(in_ready_a[0]), 64'h1);
        saw = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid_a[0]) saw = 1'b1;
        end
        check("no output for discarded op", 64'(saw), 64'h0);
        run_op(0, 32'h4110_0000, yo, invo, lat);
        check("after reset sqrt9 y", 64'(yo), 64'h40400000);
        check("after reset sqrt9 invalid", 64'(invo), 64'h0);

        fork
            run_sweep(0, 27);
            run_sweep(1, 7);
            run_sweep(2, 3);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
